psum_writeback: RTL and testbench
=================================

# psum_writeback

Drain engine downstream of the corelet's output FIFO. On a start command it pops a programmed number of psum vectors (one `col`-wide row of `psum_bw` lanes per pop) from the OFIFO and writes each one into PMEM at consecutive addresses from a programmed base. It replaces the hand-sequenced OFIFO-read and PMEM-write instruction bits with a self-timed counter and FSM, and reports completion to the top-level controller.

## Interface

Parameters:
- `col`, 8, number of psum lanes per vector
- `psum_bw`, 16, bits per psum lane
- `addr_bw`, 11, PMEM address width
- `cnt_bw`, 11, width of the vector-count field

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `start`  in  1  one-cycle command strobe; sampled only in IDLE
- `base_addr`  in  `addr_bw`  first PMEM address; captured on an accepted `start`
- `num_vec`  in  `cnt_bw`  number of vectors to drain; captured on an accepted `start`
- `ofifo_valid`  in  1  OFIFO holds at least one complete vector
- `ofifo_data`  in  `psum_bw*col`  OFIFO head vector; valid while `ofifo_valid`=1
- `ofifo_rd`  out  1  pop strobe to the OFIFO (combinational)
- `pmem_cen`  out  1  PMEM chip enable, active-low (registered)
- `pmem_wen`  out  1  PMEM write enable, active-low (registered)
- `pmem_addr`  out  `addr_bw`  PMEM address (registered)
- `pmem_d`  out  `psum_bw*col`  PMEM write data (registered)
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive
- `done`  out  1  single-cycle completion pulse

## Operation

FSM states: IDLE, DRAIN, FINISH.
- IDLE: `start`=1 captures `base_addr` into the address counter and `num_vec` into the remaining counter. If `num_vec`=0, the next state is FINISH. Otherwise the next state is DRAIN.
- DRAIN: `ofifo_rd` = `ofifo_valid` AND (remaining != 0).
  - On every cycle with `ofifo_rd`=1, the next edge registers `pmem_d`<=`ofifo_data`, `pmem_addr`<=address counter, `pmem_cen`=0 and `pmem_wen`=0. It also increments the address counter and decrements the remaining counter.
  - When the pop that makes remaining reach 0 occurs, the next state is FINISH.
  - `ofifo_valid`=0 stalls the engine with no pop and no write. The stall has no timeout.
- FINISH: `done`=1 for exactly one cycle, then the next state is IDLE.
- `start` is ignored outside IDLE. There is no queuing.
- The address counter is `addr_bw` wide and wraps modulo 2^`addr_bw` (0x7FF+1 -> 0x000). No error is flagged.
- Lane ordering is preserved bit-for-bit: lane i occupies `[psum_bw*(i+1)-1 : psum_bw*i]` in both `ofifo_data` and `pmem_d`. There is no arithmetic.
- On cycles with no write, `pmem_cen`=1 and `pmem_wen`=1. `pmem_d` and `pmem_addr` hold their last value.

## Timing

- Reset values: state=IDLE, `ofifo_rd`=0, `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0, `pmem_d`=0, `busy`=0, `done`=0, and both internal counters=0.
- Reset asserted mid-DRAIN: at the next edge the engine returns to IDLE with all outputs at their reset values.
  - Any write registered on that same edge is cancelled: `pmem_cen` is forced to 1.
  - The OFIFO is not flushed by this block.
- `start` sampled in IDLE at edge T: the earliest `ofifo_rd` is in cycle T+1.
- Pop-to-write latency is 1 cycle. A pop in cycle k produces the PMEM write strobe in cycle k+1.
- Throughput is one vector per cycle while `ofifo_valid` stays high.
- Minimum command duration with N>0 and no stalls: N DRAIN cycles plus 1 FINISH cycle.
  - The last write strobe and `done` are in the same cycle.
  - A new `start` is accepted the cycle after `done`.
- `num_vec`=0: `done` pulses at T+1 (the FINISH cycle). No pops and no writes occur.
- `ofifo_rd` is never asserted when `ofifo_valid`=0, in IDLE, or in FINISH.

## Test plan

- Reset: hold `reset` for 2 cycles -> all outputs at their reset values, `pmem_cen`/`pmem_wen`=1, `busy`=0.
- Basic drain: `base_addr`=0x010, `num_vec`=4, `ofifo_valid` held 1, vectors V0..V3 -> writes V0..V3 to 0x010..0x013 on 4 consecutive cycles, exactly 4 `ofifo_rd` pulses, `done` coincident with the 0x013 write.
- Stall: `num_vec`=3 with `ofifo_valid` toggling 1,0,0,1,0,1 -> 3 pops only on the valid cycles, writes to consecutive addresses, no write strobe during stall cycles.
- Wrap and zero count: `base_addr`=0x7FE, `num_vec`=3 -> writes to 0x7FE, 0x7FF, 0x000. A separate `num_vec`=0 command -> `done` one cycle after `start`, zero pops.
- Ignored start: pulse `start` with `base_addr`=0x100 during DRAIN of a `num_vec`=5 command at 0x020 -> writes only to 0x020..0x024 and a single `done`.
- Reset mid-operation: assert `reset` after 2 of 6 pops -> next cycle in IDLE, no further pops or writes, `done` never pulses. A following `start` with `num_vec`=2 completes normally.

Source files
------------

// File: rtl/psum_writeback_if.sv
// psum_writeback_if: bundles the command, OFIFO-read and PMEM-write signals of
// the psum drain engine.
//   command : start, base_addr, num_vec (in), busy, done (out)
//   ofifo   : ofifo_valid, ofifo_data (in), ofifo_rd (out)
//   pmem    : pmem_cen, pmem_wen, pmem_addr, pmem_d (out, registered)
// Handshake: a vector moves from the OFIFO on every cycle where
// ofifo_rd=1. ofifo_rd is only raised while ofifo_valid=1, so valid is the
// producer's offer and ofifo_rd is the consumer's accept. The OFIFO must
// advance its head on that same rising edge. PMEM sees a write on every cycle
// with pmem_cen=0 and pmem_wen=0. There is no backpressure from PMEM.
interface psum_writeback_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 11
);
    logic                     start;
    logic [addr_bw-1:0]       base_addr;
    logic [cnt_bw-1:0]        num_vec;
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_data;
    logic                     ofifo_rd;
    logic                     pmem_cen;
    logic                     pmem_wen;
    logic [addr_bw-1:0]       pmem_addr;
    logic [psum_bw*col-1:0]   pmem_d;
    logic                     busy;
    logic                     done;

    // master: the controller / OFIFO / PMEM side
    modport master (
        output start, base_addr, num_vec, ofifo_valid, ofifo_data,
        input  ofifo_rd, pmem_cen, pmem_wen, pmem_addr, pmem_d, busy, done
    );

    // slave: the drain engine itself
    modport slave (
        input  start, base_addr, num_vec, ofifo_valid, ofifo_data,
        output ofifo_rd, pmem_cen, pmem_wen, pmem_addr, pmem_d, busy, done
    );
endinterface

// File: rtl/psum_writeback.sv
// psum_writeback: drains num_vec psum vectors from the OFIFO into PMEM at
// consecutive addresses starting at base_addr. It reports busy/done to the
// top-level controller.
// Ports:
//   clk       : clock, all state on the rising edge
//   reset     : synchronous, active-high
//   bus       : psum_writeback_if.slave (command, OFIFO read, PMEM write)
//   fsm_state : current FSM state (0=IDLE, 1=DRAIN, 2=FINISH), for debug
module psum_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_writeback_if.slave      bus,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [addr_bw-1:0] addr_cnt;
    logic [cnt_bw-1:0]  remaining;
    logic               pop;

    // Pop whenever a vector is offered and the command still needs one.
    // This is the only combinational output.
    assign pop          = (state == DRAIN) && bus.ofifo_valid && (remaining != '0);
    assign bus.ofifo_rd = pop;
    assign fsm_state    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Any write launched on this edge is dropped: cen goes back to 1.
            state         <= IDLE;
            addr_cnt      <= '0;
            remaining     <= '0;
            bus.pmem_cen  <= 1'b1;
            bus.pmem_wen  <= 1'b1;
            bus.pmem_addr <= '0;
            bus.pmem_d    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            // Strobes default to idle. Address and data hold their last value.
            bus.pmem_cen <= 1'b1;
            bus.pmem_wen <= 1'b1;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_cnt  <= bus.base_addr;
                        remaining <= bus.num_vec;
                        bus.busy  <= 1'b1;
                        if (bus.num_vec == '0) begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        bus.pmem_d    <= bus.ofifo_data;
                        bus.pmem_addr <= addr_cnt;
                        bus.pmem_cen  <= 1'b0;
                        bus.pmem_wen  <= 1'b0;
                        // Wraps modulo 2^addr_bw by construction.
                        addr_cnt      <= addr_cnt + 1'b1;
                        remaining     <= remaining - 1'b1;
                        // The last pop lands its write in the FINISH cycle,
                        // so the final strobe and done coincide.
                        if (remaining == cnt_bw'(1)) begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: directed scoreboard bench for psum_writeback.
// The driver loads a modelled OFIFO, issues commands and pushes the expected
// PMEM writes into exp_q. A negedge monitor pops and compares on every write
// strobe.
module tb_psum_writeback;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_BW = 11;
    localparam int CNT_BW  = 11;
    localparam int DW      = COL * PSUM_BW;
    localparam int EW      = 1 + ADDR_BW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic [1:0] fsm_state;
    always #5 clk = ~clk;

    psum_writeback_if #(.col(COL), .psum_bw(PSUM_BW), .addr_bw(ADDR_BW), .cnt_bw(CNT_BW)) bus ();

    psum_writeback #(.col(COL), .psum_bw(PSUM_BW), .addr_bw(ADDR_BW), .cnt_bw(CNT_BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    logic rd_seen = 1'b0;
    logic gate = 1'b1;
    logic [EW-1:0] exp_q[$];        // {done, addr, data}
    logic [DW-1:0] src_q[$];        // modelled OFIFO contents
    int pat_len = 0;
    logic pat[8];
    int inj_at = -1;

    task automatic chk(input string name, input logic [EW:0] act, input logic [EW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] vec(input int k);
        logic [DW-1:0] v;
        for (int i = 0; i < COL; i++) v[PSUM_BW*i +: PSUM_BW] = 16'((k << 8) | i);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic refresh();
        bus.ofifo_valid = gate && (src_q.size() > 0);
        bus.ofifo_data  = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_seen) void'(src_q.pop_front());
        bus.start = 1'b0;
        refresh();
    endtask

    task automatic load(input int k0, input int n);
        for (int j = 0; j < n; j++) src_q.push_back(vec(k0 + j));
        refresh();
    endtask

    task automatic expect_writes(input int base, input int k0, input int n);
        logic [ADDR_BW-1:0] a;
        for (int j = 0; j < n; j++) begin
            a = ADDR_BW'(base + j);
            exp_q.push_back({(j == n - 1), a, vec(k0 + j)});
        end
    endtask

    task automatic issue(input int base, input int n);
        bus.start     = 1'b1;
        bus.base_addr = ADDR_BW'(base);
        bus.num_vec   = CNT_BW'(n);
        tick();
    endtask

    // Issue a command and wait for done; checks latency, single done and pop count.
    task automatic run_cmd(input string name, input int base, input int n, input int exp_lat);
        int d0, p0, lat;
        d0 = done_cnt;
        p0 = pop_cnt;
        issue(base, n);
        lat = 0;
        while (done_cnt == d0 && lat < 50) begin
            gate = (lat < pat_len) ? pat[lat] : 1'b1;
            refresh();
            if (lat == inj_at) begin
                bus.start     = 1'b1;
                bus.base_addr = 11'h100;
                bus.num_vec   = 11'd1;
            end
            tick();
            lat++;
        end
        gate = 1'b1;
        refresh();
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 50 cycles", name);
        end else begin
            chk({name, "_latency"}, EW'(lat), EW'(exp_lat));
        end
        tick();
        tick();
        chk({name, "_done_count"}, EW'(done_cnt - d0), EW'(1));
        chk({name, "_pop_count"}, EW'(pop_cnt - p0), EW'(n));
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] exp_e;
    always @(negedge clk) begin
        rd_seen = bus.ofifo_rd;
        if (bus.ofifo_rd) begin
            pop_cnt++;
            chk("rd_needs_valid", EW'(bus.ofifo_valid), EW'(1));
        end
        if (bus.done) done_cnt++;
        if (!bus.pmem_cen || !bus.pmem_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", bus.pmem_addr, bus.pmem_d);
            end else begin
                exp_e = exp_q.pop_front();
                chk("write", {bus.pmem_cen, bus.pmem_wen, bus.done, bus.pmem_addr, bus.pmem_d},
                    {2'b00, exp_e});
            end
        end
    end

    // ---------------- stimulus ----------------
    int p0, d0;
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_vec = '0;
        refresh();
        tick();
        tick();
        @(negedge clk);
        chk("reset_outputs", EW'({bus.ofifo_rd, bus.pmem_cen, bus.pmem_wen, bus.busy, bus.done}),
            EW'(5'b01100));
        chk("reset_addr_data", EW'({bus.pmem_addr, bus.pmem_d}), EW'(0));
        reset = 1'b0;
        tick();

        // basic drain
        load(0, 4);
        expect_writes(11'h010, 0, 4);
        run_cmd("basic", 11'h010, 4, 5);

        // busy spans the command
        @(negedge clk);
        chk("idle_busy", EW'(bus.busy), EW'(0));
        tick();

        // stall pattern 1,0,0,1,0,1
        load(10, 3);
        expect_writes(11'h200, 10, 3);
        pat_len = 6;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        run_cmd("stall", 11'h200, 3, 7);
        pat_len = 0;

        // address wrap
        load(20, 3);
        expect_writes(11'h7FE, 20, 3);
        run_cmd("wrap", 11'h7FE, 3, 4);

        // zero count, vector available but must not be popped
        load(99, 1);
        run_cmd("zero", 11'h300, 0, 1);
        src_q.delete();
        refresh();

        // start during DRAIN is ignored
        load(30, 5);
        expect_writes(11'h020, 30, 5);
        inj_at = 1;
        run_cmd("ignored_start", 11'h020, 5, 6);
        inj_at = -1;

        // reset after two pops: second write cancelled, no done
        load(40, 6);
        exp_q.push_back({1'b0, 11'h040, vec(40)});
        p0 = pop_cnt;
        d0 = done_cnt;
        issue(11'h040, 6);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_idle", EW'({bus.ofifo_rd, bus.pmem_cen, bus.busy, bus.done}), EW'(4'b0100));
        tick();
        tick();
        tick();
        chk("midreset_pops", EW'(pop_cnt - p0), EW'(2));
        chk("midreset_no_done", EW'(done_cnt - d0), EW'(0));

        // leftover vectors 42.. remain in the OFIFO
        expect_writes(11'h050, 42, 2);
        run_cmd("after_reset", 11'h050, 2, 3);

        chk("scoreboard_empty", EW'(exp_q.size()), EW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
